counted_shift_capture: RTL

- Parametrised serial-to-parallel capture unit: a loadable up-counter gates a shift register, so exactly (2^CNT_W-1 - init) serial bits are captured after each load.
- Next generation of the fixed 8-bit counter plus shift-register pair.
- Adds generic widths, selectable shift direction, explicit FSM, done/valid flags and pause via en.
- Sits between a serial input line and parallel consumers.

---
 rtl/counted_shift_capture.sv | 130 +++++++++++++
 1 files changed

// File: rtl/counted_shift_capture.sv
// counted_shift_capture: serial-to-parallel capture unit.
// A load primes the bit counter with `init`; each enabled cycle in SHIFT
// moves one serial bit into `dout` and bumps the counter. Capture ends when
// the counter reaches its all-ones value, so MAX-init bits are taken per load.
//
// Handshake: there is no back-pressure. `done` is a single-cycle pulse that
// marks the cycle in which a fresh capture first becomes visible; `dout_valid`
// is a level that stays high from that cycle until the next load or reset.
module counted_shift_capture #(
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              en,
  input  logic [CNT_W-1:0]  init,
  input  logic              si,
  output logic [DATA_W-1:0] dout,
  output logic [CNT_W-1:0]  cnt,
  output logic              tc,
  output logic              busy,
  output logic              done,
  output logic              dout_valid,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t              r_state;
  state_t              w_next;
  logic [DATA_W-1:0]   r_dout;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_done;
  logic                w_shift;
  logic                w_last;
  logic                w_zero_len;
  logic [DATA_W-1:0]   w_dout_shifted;

  // A shift happens only in SHIFT, not on a load cycle, and only while enabled.
  assign w_shift    = (r_state == S_SHIFT) && !load && en;
  // The shift that lands the counter on MAX is the final one.
  assign w_last     = w_shift && (r_cnt == CNT_LAST);
  // Loading MAX means there is nothing to capture.
  assign w_zero_len = (init == CNT_MAX);

  // Next capture register value, direction fixed by LSB_FIRST.
  always_comb begin
    w_dout_shifted = r_dout;
    if (LSB_FIRST) begin
      w_dout_shifted = {si, r_dout[DATA_W-1:1]};
    end else begin
      w_dout_shifted = {r_dout[DATA_W-2:0], si};
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: load wins over everything except reset.
  always_comb begin
    w_next = r_state;
    if (load) begin
      w_next = w_zero_len ? S_DONE : S_SHIFT;
    end else begin
      case (r_state)
        S_IDLE:  w_next = S_IDLE;
        S_SHIFT: w_next = w_last ? S_DONE : S_SHIFT;
        S_DONE:  w_next = S_DONE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // State-decoded outputs.
  always_comb begin
    busy       = 1'b0;
    dout_valid = 1'b0;
    case (r_state)
      S_SHIFT: busy       = 1'b1;
      S_DONE:  dout_valid = 1'b1;
      default: begin
        busy       = 1'b0;
        dout_valid = 1'b0;
      end
    endcase
  end

  // Datapath: capture register, bit counter and the registered done pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_dout <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (load) begin
      r_dout <= '0;
      r_cnt  <= init;
      r_done <= w_zero_len;
    end else begin
      r_done <= 1'b0;
      if (w_shift) begin
        r_dout <= w_dout_shifted;
        r_cnt  <= r_cnt + CNT_ONE;
        r_done <= w_last;
      end
    end
  end

  assign dout      = r_dout;
  assign cnt       = r_cnt;
  assign done      = r_done;
  assign tc        = (r_cnt == CNT_MAX);
  assign dbg_state = r_state;

endmodule
